pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_entry.sv | 33 +++
 rtl/pipe_stage_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: exception codes and
// occupancy-state encoding.
package pipe_pkg;

    // Exception code width; code 0 means no exception.
    localparam int unsigned EXC_W = 5;

    // Exception codes carried down the pipeline alongside each instruction.
    localparam logic [EXC_W-1:0] ExcInt  = 5'd0;
    localparam logic [EXC_W-1:0] ExcAdel = 5'd4;
    localparam logic [EXC_W-1:0] ExcAdes = 5'd5;
    localparam logic [EXC_W-1:0] ExcRi   = 5'd10;
    localparam logic [EXC_W-1:0] ExcOv   = 5'd12;

    // Occupancy states; the encoding equals the entry count so occ can be the state itself.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: payload plus merged exception code, with load enable
// and a clear that takes priority over the load.
module pipe_entry #(
    parameter int unsigned PAY_W = 104,
    parameter int unsigned EXC_W = 5
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [PAY_W-1:0] payload_i,
    input  logic [EXC_W-1:0] exc_i,
    output logic [PAY_W-1:0] payload_o,
    output logic [EXC_W-1:0] exc_o
);

    logic [PAY_W-1:0] payload_q;
    logic [EXC_W-1:0] exc_q;

    // Slot register: clear zeroes the contents so an empty slot reads as a NOP.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            payload_q <= '0;
            exc_q     <= '0;
        end else if (ld_i) begin
            payload_q <= payload_i;
            exc_q     <= exc_i;
        end
    end

    assign payload_o = payload_q;
    assign exc_o     = exc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer.
// The main slot drives out_*; the skid slot absorbs one overflow entry so
// that in_ready can be registered and out_ready never reaches in_ready
// combinationally.
import pipe_pkg::*;

module pipe_stage_reg #(
    parameter int unsigned PAY_W = 104,
    parameter int unsigned EXC_W = pipe_pkg::EXC_W,
    parameter int unsigned SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAY_W-1:0] in_payload,
    input  logic [EXC_W-1:0] in_exc,
    input  logic             loc_exc_v,
    input  logic [EXC_W-1:0] loc_exc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] out_payload,
    output logic [EXC_W-1:0] out_exc,
    output logic [1:0]       occ
);

    pipe_state_e state_q, state_d;

    logic             push;
    logic             pop;
    logic [EXC_W-1:0] merged_exc;

    logic             main_ld;
    logic             main_clr;
    logic             main_sel_skid;
    logic [PAY_W-1:0] main_d_payload;
    logic [EXC_W-1:0] main_d_exc;
    logic [PAY_W-1:0] main_payload;
    logic [EXC_W-1:0] main_exc;

    logic             skid_ld;
    logic             skid_clr;
    logic [PAY_W-1:0] skid_payload;
    logic [EXC_W-1:0] skid_exc;

    assign push      = in_valid & in_ready;
    assign out_valid = (state_q != StEmpty);
    assign pop       = out_valid & out_ready;
    assign occ       = state_q;

    // Earliest stage wins: an inherited code masks any locally raised one.
    always_comb begin
        merged_exc = '0;
        if (in_exc != '0) begin
            merged_exc = in_exc;
        end else if (loc_exc_v) begin
            merged_exc = loc_exc;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot load controls; flush overrides everything.
    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        main_sel_skid = 1'b0;
        skid_ld       = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    main_ld = 1'b1;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_ld = 1'b1;
                end else if (push) begin
                    // Only reachable with a skid slot; without it in_ready is low here.
                    if (SKID != 0) begin
                        state_d = StTwo;
                        skid_ld = 1'b1;
                    end
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    state_d       = StOne;
                    main_ld       = 1'b1;
                    main_sel_skid = 1'b1;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        if (flush) begin
            state_d       = StEmpty;
            main_ld       = 1'b0;
            main_sel_skid = 1'b0;
            skid_ld       = 1'b0;
        end
    end

    // Main slot is zeroed whenever the stage goes empty so bubbles read as NOP.
    always_comb begin
        main_clr       = reset | (state_d == StEmpty);
        skid_clr       = reset | flush | ((state_q == StTwo) & pop);
        main_d_payload = main_sel_skid ? skid_payload : in_payload;
        main_d_exc     = main_sel_skid ? skid_exc : merged_exc;
    end

    pipe_entry #(
        .PAY_W (PAY_W),
        .EXC_W (EXC_W)
    ) u_main (
        .clk       (clk),
        .clr_i     (main_clr),
        .ld_i      (main_ld),
        .payload_i (main_d_payload),
        .exc_i     (main_d_exc),
        .payload_o (main_payload),
        .exc_o     (main_exc)
    );

    assign out_payload = main_payload;
    assign out_exc     = main_exc;

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            pipe_entry #(
                .PAY_W (PAY_W),
                .EXC_W (EXC_W)
            ) u_skid (
                .clk       (clk),
                .clr_i     (skid_clr),
                .ld_i      (skid_ld),
                .payload_i (in_payload),
                .exc_i     (merged_exc),
                .payload_o (skid_payload),
                .exc_o     (skid_exc)
            );

            // Registered ready: tracks whether the next cycle has a free slot.
            always_ff @(posedge clk) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != StTwo);
                end
            end

            assign in_ready = in_ready_q;

            a_ready_matches_occ : assert property (
                @(posedge clk) disable iff (reset) in_ready == (state_q != StTwo));
        end else begin : g_noskid
            assign skid_payload = '0;
            assign skid_exc     = '0;
            // Single slot: accept when empty or when the held entry leaves now.
            assign in_ready     = ~out_valid | out_ready;

            a_never_two : assert property (
                @(posedge clk) disable iff (reset) state_q != StTwo);
        end
    endgenerate

    a_bubble_is_nop : assert property (
        @(posedge clk) disable iff (reset)
        !out_valid |-> (out_payload == '0 && out_exc == '0));

    a_hold_on_stall : assert property (
        @(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> ($stable(out_payload) && $stable(out_exc)));

endmodule
